// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline stage with valid/ready handshake and a two-entry skid buffer.
// Optional back-pressure counter is built when MEM_WB_SKID_STALL_CNT_EN is defined.
module mem_wb_skid_stage #(
  parameter int B = 32,
  parameter int W = 5,
  parameter int C = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [B-1:0] in_read_data,
  input  logic [B-1:0] in_alu_result,
  input  logic [W-1:0] in_reg_dst,
  input  logic [C-1:0] in_ctrl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [B-1:0] out_read_data,
  output logic [B-1:0] out_alu_result,
  output logic [W-1:0] out_reg_dst,
  output logic [C-1:0] out_ctrl,
  output logic [1:0]   occupancy,
  output logic [15:0]  stall_cnt
);

  localparam int P = 2*B + W + C;

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]   state_reg, state_next;
  logic [P-1:0] main_reg, main_next;
  logic [P-1:0] skid_reg, skid_next;
  logic [P-1:0] in_payload;
  logic         in_fire, out_fire;

  assign in_payload = {in_read_data, in_alu_result, in_reg_dst, in_ctrl};
  assign in_ready   = (state_reg != ST_FULL);
  assign out_valid  = (state_reg != ST_EMPTY);
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;

  // Control bits of any register that stops holding a valid entry are cleared,
  // so out_ctrl is zero whenever out_valid is low.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next         = ST_EMPTY;
      main_next[C-1:0]   = '0;
      skid_next[C-1:0]   = '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            main_next  = in_payload;
            state_next = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_next = in_payload;
          end else if (in_fire) begin
            skid_next  = in_payload;
            state_next = ST_FULL;
          end else if (out_fire) begin
            main_next[C-1:0] = '0;
            state_next       = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_next        = skid_reg;
            skid_next[C-1:0] = '0;
            state_next       = ST_BUSY;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  assign out_read_data  = main_reg[P-1 -: B];
  assign out_alu_result = main_reg[P-B-1 -: B];
  assign out_reg_dst    = main_reg[C+W-1 -: W];
  assign out_ctrl       = main_reg[C-1:0];
  assign occupancy      = state_reg;

`ifdef MEM_WB_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  // Saturating; only reset clears it so stall history survives a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
